// File: rtl/sys_clkgen.sv
// Programmable refclk divider bank: NUM_CH clocks + CE pulses, first rise 1+PHASE cycles after a sync, no backpressure.
// Runtime div/phase writes exist only when SYS_CLKGEN_DYNCFG_EN is defined; otherwise settings are the reset constants.
module sys_clkgen #(
   parameter int unsigned                NUM_CH      = 2,
   parameter int unsigned                DIV_W       = 8,
   parameter logic [NUM_CH*DIV_W-1:0]    DIV_INIT    = {8'd40, 8'd5},
   parameter logic [NUM_CH*DIV_W-1:0]    PHASE_INIT  = '0,
   parameter int unsigned                LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_ch,
   input  logic              cfg_sel,
   input  logic [DIV_W-1:0]  cfg_data,
   output logic              cfg_ready,
   output logic [NUM_CH-1:0] clkc,
   output logic [NUM_CH-1:0] clkc_ce,
   output logic              extlock
);

   typedef enum logic [1:0] {CH_IDLE, CH_DELAY, CH_RUN} ch_state_e;

   ch_state_e         st_q   [NUM_CH];
   ch_state_e         st_d   [NUM_CH];
   logic [DIV_W-1:0]  cnt_q  [NUM_CH];
   logic [DIV_W-1:0]  cnt_d  [NUM_CH];
   logic [DIV_W-1:0]  dly_q  [NUM_CH];
   logic [DIV_W-1:0]  dly_d  [NUM_CH];
   logic [DIV_W-1:0]  div_eff[NUM_CH];
   logic [DIV_W-1:0]  ph_eff [NUM_CH];
   logic [DIV_W-1:0]  d_eff  [NUM_CH];
   logic [DIV_W:0]    h_eff  [NUM_CH];
   logic [NUM_CH-1:0] clk_q, clk_d, ce_q, ce_d;
   logic              started_q;
   logic              lock_q, lock_d;
   logic [15:0]       lock_cnt_q, lock_cnt_d;
   logic              cfg_acc;
   logic              sync_all;

`ifdef SYS_CLKGEN_DYNCFG_EN
   logic [DIV_W-1:0] div_q[NUM_CH];
   logic [DIV_W-1:0] div_d[NUM_CH];
   logic [DIV_W-1:0] ph_q [NUM_CH];
   logic [DIV_W-1:0] ph_d [NUM_CH];

   assign cfg_acc   = cfg_we && lock_q && ({1'b0, cfg_ch} < 5'(NUM_CH));
   assign cfg_ready = lock_q;

   // The freshly written value is what the resync on the same edge must use.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         div_d[i] = div_q[i];
         ph_d[i]  = ph_q[i];
         if (cfg_acc && cfg_ch == 4'(i)) begin
            if (cfg_sel) ph_d[i]  = cfg_data;
            else         div_d[i] = cfg_data;
         end
         div_eff[i] = div_d[i];
         ph_eff[i]  = ph_d[i];
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
            ph_q[i]  <= PHASE_INIT[i*DIV_W +: DIV_W];
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= div_d[i];
            ph_q[i]  <= ph_d[i];
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{cfg_we, cfg_ch, cfg_sel, cfg_data};
   assign cfg_acc    = 1'b0;
   assign cfg_ready  = 1'b0;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         div_eff[i] = DIV_INIT[i*DIV_W +: DIV_W];
         ph_eff[i]  = PHASE_INIT[i*DIV_W +: DIV_W];
      end
   end
`endif

   assign sync_all = !started_q || cfg_acc;

   always_comb begin
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt_q;
      if (sync_all) begin
         lock_d     = 1'b0;
         lock_cnt_d = 16'd1;
      end else if (!lock_q) begin
         if (lock_cnt_q == 16'(LOCK_CYCLES)) lock_d = 1'b1;
         else                                lock_cnt_d = lock_cnt_q + 16'd1;
      end
   end

   // Divide 0 runs as divide 1; high phase is the rounded-up half period.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         d_eff[i] = (div_eff[i] == '0) ? DIV_W'(1) : div_eff[i];
         h_eff[i] = ({1'b0, d_eff[i]} + 1'b1) >> 1;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         dly_d[i] = dly_q[i];
         clk_d[i] = 1'b0;
         ce_d[i]  = 1'b0;
         if (!ch_en[i]) begin
            st_d[i]  = CH_IDLE;
            cnt_d[i] = '0;
            dly_d[i] = '0;
         end else if (sync_all || st_q[i] == CH_IDLE) begin
            cnt_d[i] = '0;
            dly_d[i] = ph_eff[i];
            st_d[i]  = (ph_eff[i] == '0) ? CH_RUN : CH_DELAY;
         end else if (st_q[i] == CH_DELAY) begin
            if (dly_q[i] <= DIV_W'(1)) st_d[i]  = CH_RUN;
            else                       dly_d[i] = dly_q[i] - DIV_W'(1);
         end else begin
            clk_d[i] = ({1'b0, cnt_q[i]} < h_eff[i]);
            ce_d[i]  = (cnt_q[i] == '0);
            cnt_d[i] = (cnt_q[i] == d_eff[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         started_q  <= 1'b0;
         lock_q     <= 1'b0;
         lock_cnt_q <= '0;
         clk_q      <= '0;
         ce_q       <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]  <= CH_IDLE;
            cnt_q[i] <= '0;
            dly_q[i] <= '0;
         end
      end else begin
         started_q  <= 1'b1;
         lock_q     <= lock_d;
         lock_cnt_q <= lock_cnt_d;
         clk_q      <= clk_d;
         ce_q       <= ce_d;
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
            dly_q[i] <= dly_d[i];
         end
      end
   end

   assign clkc    = clk_q;
   assign clkc_ce = ce_q;
   assign extlock = lock_q;

endmodule
